// File: rtl/plru_tree.sv
// plru_tree: N-way tree pseudo-LRU replacement engine.
// Keeps WAYS-1 heap-ordered tree bits per set. A lookup returns a registered
// victim (invalid ways first, then the tree walk). An access marks a way MRU.
// A flush clears one set per cycle over SETS cycles.
// Optional feature macro: PLRU_WAY_LOCK_EN enables per-way eviction locking
// through lock_mask_i and drives victim_blocked_o.
//
// Handshake: lookup_valid_i and access_valid_i are single-cycle strobes.
// They are accepted only when the engine is idle and flush_i is low; there
// is no back-pressure. victim_valid_o is a one-cycle pulse following each
// accepted lookup. The victim_* data outputs hold their values between
// pulses.
module plru_tree #(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WIDTH = 512,
  localparam int SET_W     = $clog2(SETS),
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       lookup_valid_i,
  input  logic [SET_W-1:0]           lookup_set_i,
  input  logic [WAYS-1:0]            way_valid_i,
  input  logic [WAYS*LINE_WIDTH-1:0] way_lines_i,
  input  logic [WAYS-1:0]            lock_mask_i,
  input  logic                       access_valid_i,
  input  logic [SET_W-1:0]           access_set_i,
  input  logic [WAY_W-1:0]           access_way_i,
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic                       victim_valid_o,
  output logic [WAY_W-1:0]           victim_way_o,
  output logic [LINE_WIDTH-1:0]      victim_line_o,
  output logic                       victim_blocked_o,
  output logic                       state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SET_W-1:0]    cnt_q;
  logic [WAYS-2:0]     tree_q [SETS];
  logic                accept;
  logic [WAYS-2:0]     tree_rd;
  logic [WAY_W-1:0]    walk_way;
  logic [WAY_W-1:0]    sel_way;
  logic                sel_blocked;

  // Set every node on the path to way w so that it points away from w.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t,
                                            input logic [WAY_W-1:0] w);
    logic [WAYS-2:0] r;
    int idx;
    logic dir;
    r   = t;
    idx = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = w[WAY_W-1-l];
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == idx) r[n] = ~dir;
      end
      idx = dir ? (2*idx + 2) : (2*idx + 1);
    end
    return r;
  endfunction

  // Follow the tree bits from the root down to a leaf (0 = left, 1 = right).
  function automatic logic [WAY_W-1:0] walk(input logic [WAYS-2:0] t);
    int idx;
    logic b;
    idx = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == idx) b = t[n];
      end
      idx = b ? (2*idx + 2) : (2*idx + 1);
    end
    return WAY_W'(idx - (WAYS-1));
  endfunction

  assign accept  = (state_q == ST_IDLE) && !flush_i;
  assign busy_o  = (state_q == ST_FLUSH);
  assign state_o = state_q;

  // Next-state logic: idle until flush_i, then sweep through every set once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_i) state_d = ST_FLUSH;
      ST_FLUSH: if (cnt_q == SET_W'(SETS-1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Victim selection for the set being looked up (pre-update tree).
  always_comb begin
    tree_rd     = tree_q[lookup_set_i];
    walk_way    = walk(tree_rd);
    sel_way     = walk_way;
    sel_blocked = 1'b0;
`ifdef PLRU_WAY_LOCK_EN
    if (lock_mask_i[walk_way]) begin
      sel_blocked = 1'b1;
      sel_way     = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
        if (!lock_mask_i[w]) begin
          sel_blocked = 1'b0;
          sel_way     = WAY_W'(w);
        end
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!way_valid_i[w] && !lock_mask_i[w]) sel_way = WAY_W'(w);
    end
`else
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!way_valid_i[w]) sel_way = WAY_W'(w);
    end
`endif
  end

`ifndef PLRU_WAY_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock_mask_i;
`endif

  // FSM register, sweep counter and tree storage (flush clears, access updates).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) begin
        tree_q[cnt_q] <= '0;
        cnt_q         <= cnt_q + SET_W'(1);
      end else if (accept && access_valid_i) begin
        tree_q[access_set_i] <= touch(tree_q[access_set_i], access_way_i);
      end
    end
  end

  // Registered victim outputs; data holds when no lookup is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_valid_o   <= 1'b0;
      victim_way_o     <= '0;
      victim_line_o    <= '0;
      victim_blocked_o <= 1'b0;
    end else begin
      victim_valid_o <= accept && lookup_valid_i;
      if (accept && lookup_valid_i) begin
        victim_way_o     <= sel_way;
        victim_line_o    <= way_lines_i[int'(sel_way)*LINE_WIDTH +: LINE_WIDTH];
        victim_blocked_o <= sel_blocked;
      end
    end
  end

endmodule
